// File: rtl/sig_mixer.sv
// N-channel waveform mixer: ramped per-voice gains, gated LFSR noise voice,
// three-stage multiply / sum / saturate pipeline with a sticky clip flag.

// One mixer voice: click-free gain ramp plus the registered first-stage product.
module sig_mixer_voice #(
  parameter int W      = 16,
  parameter int GAIN_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_en,
  input  logic [W-1:0]          src,
  input  logic [GAIN_W-1:0]     target,
  output logic [W+GAIN_W-1:0]   p
);
  localparam int PW = W + GAIN_W;

  logic [GAIN_W-1:0] g_cur;

  // The product uses the gain from before this strobe's ramp step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_cur <= '0;
      p     <= '0;
    end else if (sample_en) begin
      p <= PW'(src) * PW'(g_cur);
      if (g_cur < target) begin
        g_cur <= g_cur + 1'b1;
      end else if (g_cur > target) begin
        g_cur <= g_cur - 1'b1;
      end
    end
  end
endmodule

module sig_mixer #(
  parameter int          N_CH       = 4,
  parameter int          W          = 16,
  parameter int          GAIN_W     = 4,
  parameter logic [15:0] NOISE_SEED = 16'h0305
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_en,
  input  logic [N_CH-1:0]          ch_en,
  input  logic [N_CH*W-1:0]        ch_sig,
  input  logic [N_CH*GAIN_W-1:0]   ch_gain,
  input  logic                     noise_en,
  input  logic [GAIN_W-1:0]        noise_gain,
  input  logic                     clip_clr,
  output logic [W-1:0]             sig,
  output logic                     sig_valid,
  output logic                     clip
);
  localparam int          NV   = N_CH + 1;
  localparam int          PW   = W + GAIN_W;
  localparam int          AW   = PW + $clog2(N_CH + 1);
  localparam logic [15:0] SEED = (NOISE_SEED == 16'd0) ? 16'h0001 : NOISE_SEED;

  logic [W-1:0]      src    [NV];
  logic [GAIN_W-1:0] target [NV];
  logic [PW-1:0]     p      [NV];

  logic [15:0]       lfsr;
  logic [W-1:0]      noise_term;

  logic              v1_reg;
  logic              v2_reg;
  logic [AW-1:0]     acc_reg;
  logic [AW-1:0]     sum_comb;
  logic [AW-1:0]     y_full;
  logic              sat;

  // Oscillator voices occupy slots 0..N_CH-1, the noise voice the last slot.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign src[gi]    = ch_sig[gi*W +: W];
      assign target[gi] = ch_en[gi] ? ch_gain[gi*GAIN_W +: GAIN_W] : '0;
    end
  endgenerate

  assign src[N_CH]    = noise_term;
  assign target[N_CH] = noise_en ? noise_gain : '0;

  generate
    if (W == 16) begin : g_noise_eq
      assign noise_term = lfsr;
    end else if (W > 16) begin : g_noise_wide
      assign noise_term = {lfsr, {(W-16){1'b0}}};
    end else begin : g_noise_narrow
      assign noise_term = lfsr[15 -: W];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NV; gi++) begin : g_voice
      sig_mixer_voice #(
        .W      (W),
        .GAIN_W (GAIN_W)
      ) u_voice (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .src       (src[gi]),
        .target    (target[gi]),
        .p         (p[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (sample_en && noise_en) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3]};
    end
  end

  // Accumulator is wide enough for every voice at full scale and max gain.
  always_comb begin
    sum_comb = '0;
    for (int i = 0; i < NV; i++) begin
      sum_comb = sum_comb + AW'(p[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg  <= 1'b0;
      v2_reg  <= 1'b0;
      acc_reg <= '0;
    end else begin
      v1_reg  <= sample_en;
      v2_reg  <= v1_reg;
      acc_reg <= sum_comb;
    end
  end

  assign y_full = acc_reg >> (GAIN_W - 1);
  assign sat    = |y_full[AW-1:W];

  // Clip is set-dominant so a saturation is never lost to a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig       <= '0;
      sig_valid <= 1'b0;
      clip      <= 1'b0;
    end else begin
      sig_valid <= v2_reg;
      if (v2_reg) begin
        sig <= sat ? '1 : y_full[W-1:0];
      end
      if (v2_reg && sat) begin
        clip <= 1'b1;
      end else if (clip_clr) begin
        clip <= 1'b0;
      end
    end
  end
endmodule
